ledport_pwm_fta32: RTL and testbench

//  FTA32 bus slave driving NLED indicator LEDs; successor to the fixed 8-bit LED latch.

---
 rtl/ledport_pwm_fta32_if.sv | 31 +++
 rtl/ledport_pwm_fta32.sv | 118 +++++++++++
 tb/tb_ledport_pwm_fta32.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ledport_pwm_fta32_if.sv
// FTA32 command bus between the peripheral decoder/master and the LED port slave.
// Carries the decoder's slave select alongside the request and response records.
interface ledport_pwm_fta32_if;
    typedef struct packed {
        logic        cyc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] padr;
        logic [31:0] dat;
        logic [3:0]  cid;
        logic [7:0]  tid;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] dat;
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic [31:0] adr;
        logic        err;
        logic        rty;
        logic [3:0]  pri;
    } fta_cmd_response32_t;

    logic                cs;
    fta_cmd_request32_t  req;
    fta_cmd_response32_t resp;

    modport master (output cs, output req, input resp);
    modport slave  (input cs, input req, output resp);
endinterface

// File: rtl/ledport_pwm_fta32.sv
// FTA32 slave driving NLED indicator LEDs with byte-lane register writes,
// readback, per-LED blink from a shared prescaler and global PWM brightness.
module ledport_pwm_fta32 #(
    parameter int                 NLED         = 8,
    parameter int                 PRE_W        = 24,
    parameter logic [PRE_W-1:0]   PRESCALE_RST = 24'd12499999
) (
    input  logic                         clk,
    input  logic                         rst,
    ledport_pwm_fta32_if.slave           fta_io,
    output logic [NLED-1:0]              led_o
);
    logic [NLED-1:0]  data_q, data_d, blink_q, blink_d, led_q, led_d;
    logic [PRE_W-1:0] pre_q, pre_d, pre_cnt_q, pre_cnt_d;
    logic [7:0]       bright_q, bright_d, pwm_cnt_q, pwm_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdat_q, rdat_d, adr_q, adr_d;
    logic [3:0]       cid_q, cid_d;
    logic [7:0]       tid_q, tid_d;

    logic             acc, wr, pwm_on;
    logic [1:0]       ridx;
    logic [31:0]      rd_mux, merged;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        acc    = fta_io.cs & fta_io.req.cyc;
        wr     = acc & fta_io.req.we;
        ridx   = fta_io.req.padr[3:2];
        case (ridx)
            2'd0:    rd_mux = 32'(data_q);
            2'd1:    rd_mux = 32'(blink_q);
            2'd2:    rd_mux = 32'(pre_q);
            default: rd_mux = 32'(bright_q);
        endcase
        merged = lane_merge(rd_mux, fta_io.req.dat, fta_io.req.sel);

        data_d   = data_q;
        blink_d  = blink_q;
        pre_d    = pre_q;
        bright_d = bright_q;
        if (wr) begin
            case (ridx)
                2'd0:    data_d   = NLED'(merged);
                2'd1:    blink_d  = NLED'(merged);
                2'd2:    pre_d    = PRE_W'(merged);
                default: bright_d = 8'(merged);
            endcase
        end

        // A PRE write restarts the count from the new value without a phase flip.
        blink_ph_d = blink_ph_q;
        if (wr && ridx == 2'd2) begin
            pre_cnt_d = PRE_W'(merged);
        end else if (pre_cnt_q == '0) begin
            pre_cnt_d  = pre_q;
            blink_ph_d = ~blink_ph_q;
        end else begin
            pre_cnt_d = pre_cnt_q - 1'b1;
        end

        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_on    = (bright_q == 8'hFF) | (pwm_cnt_q < bright_q);
        led_d     = data_q & (~blink_q | {NLED{blink_ph_q}}) & {NLED{pwm_on}};

        ack_d  = acc;
        rdat_d = (acc && !fta_io.req.we) ? rd_mux : 32'd0;
        cid_d  = acc ? fta_io.req.cid  : 4'd0;
        tid_d  = acc ? fta_io.req.tid  : 8'd0;
        adr_d  = acc ? fta_io.req.padr : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            blink_q    <= '0;
            pre_q      <= PRESCALE_RST;
            bright_q   <= 8'hFF;
            pre_cnt_q  <= PRESCALE_RST;
            blink_ph_q <= 1'b0;
            pwm_cnt_q  <= 8'd0;
            led_q      <= '0;
            ack_q      <= 1'b0;
            rdat_q     <= 32'd0;
            cid_q      <= 4'd0;
            tid_q      <= 8'd0;
            adr_q      <= 32'd0;
        end else begin
            data_q     <= data_d;
            blink_q    <= blink_d;
            pre_q      <= pre_d;
            bright_q   <= bright_d;
            pre_cnt_q  <= pre_cnt_d;
            blink_ph_q <= blink_ph_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_q      <= led_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            cid_q      <= cid_d;
            tid_q      <= tid_d;
            adr_q      <= adr_d;
        end
    end

    assign led_o       = led_q;
    assign fta_io.resp = {ack_q, rdat_q, cid_q, tid_q, adr_q, 1'b0, 1'b0, 4'd7};
endmodule

// File: tb/tb_ledport_pwm_fta32.sv
// Directed bench for ledport_pwm_fta32 (NLED=32): register table plus blink,
// PWM, streaming and reset corner sequences.
module tb_ledport_pwm_fta32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] led;
    int          total = 0;
    int          bad   = 0;

    ledport_pwm_fta32_if bus ();

    ledport_pwm_fta32 #(.NLED(32), .PRE_W(24), .PRESCALE_RST(24'd12499999)) dut (
        .clk    (clk),
        .rst    (rst),
        .fta_io (bus.slave),
        .led_o  (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp_d;
    } vec_t;
    vec_t vt[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic cs, input logic cyc, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] wd,
                         input logic [3:0] cid, input logic [7:0] tid);
        bus.cs       = cs;
        bus.req.cyc  = cyc;
        bus.req.we   = we;
        bus.req.padr = adr;
        bus.req.sel  = sel;
        bus.req.dat  = wd;
        bus.req.cid  = cid;
        bus.req.tid  = tid;
    endtask

    // One access: drive at a falling edge, sample the response at the next one.
    task automatic access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [3:0] cid, input logic [7:0] tid,
                          output logic ack, output logic [31:0] rd);
        @(negedge clk);
        drive(1'b1, 1'b1, we, adr, sel, wd, cid, tid);
        @(negedge clk);
        ack = bus.resp.ack;
        rd  = bus.resp.dat;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 8'd0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
        logic a;
        logic [31:0] r;
        access(1'b1, adr, 4'hF, wd, 4'd0, 8'd0, a, r);
    endtask

    initial begin
        logic        a;
        logic [31:0] r;
        int          cnt, badv, last, ntog, badint;
        logic        prev;
        logic [31:0] sexp[5];

        vt[0]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_0000};
        vt[1]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'h0000_0000};
        vt[2]  = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,         32'h00BE_BC1F};
        vt[3]  = '{1'b0, 32'h0000_000C, 4'h0, 32'h0,         32'h0000_00FF};
        vt[4]  = '{1'b1, 32'h0000_0000, 4'h5, 32'h1122_3344, 32'h0000_0000};
        vt[5]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0022_0044};
        vt[6]  = '{1'b1, 32'h0000_0010, 4'hA, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[7]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'hFF22_FF44};
        vt[8]  = '{1'b1, 32'h0000_000C, 4'hF, 32'h1234_5678, 32'h0000_0000};
        vt[9]  = '{1'b0, 32'h8000_000C, 4'h0, 32'h0,         32'h0000_0078};
        vt[10] = '{1'b1, 32'h0000_0008, 4'hF, 32'hAABB_CCDD, 32'h0000_0000};
        vt[11] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,         32'h00BB_CCDD};
        vt[12] = '{1'b1, 32'h0000_000C, 4'h0, 32'h0,         32'h0000_0000};
        vt[13] = '{1'b0, 32'h0000_000C, 4'h0, 32'h0,         32'h0000_0078};
        vt[14] = '{1'b1, 32'h0000_0004, 4'h3, 32'h0000_FFFF, 32'h0000_0000};
        vt[15] = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'h0000_FFFF};

        drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("reset_led", led, 32'd0);
        check("reset_ack", 32'(bus.resp.ack), 32'd0);
        check("resp_pri", 32'(bus.resp.pri), 32'd7);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            access(vt[i].we, vt[i].adr, vt[i].sel, vt[i].wd, 4'(i), 8'(8'h40 + i), a, r);
            check($sformatf("vec%0d_ack", i), 32'(a), 32'd1);
            check($sformatf("vec%0d_dat", i), r, vt[i].exp_d);
            check($sformatf("vec%0d_adr", i), bus.resp.adr, vt[i].adr);
        end
        @(negedge clk);
        check("idle_ack", 32'(bus.resp.ack), 32'd0);
        check("idle_dat", bus.resp.dat, 32'd0);

        wr(32'hC, 32'hFF);
        wr(32'h4, 32'h0);
        wr(32'h0, 32'h0);
        @(negedge clk);

        // Single DATA write: ack with echoed ids, led follows one edge later.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h0, 4'b0001, 32'h0000_00A5, 4'd5, 8'h3C);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 8'd0);
        check("wr_ack", 32'(bus.resp.ack), 32'd1);
        check("wr_cid", 32'(bus.resp.cid), 32'd5);
        check("wr_tid", 32'(bus.resp.tid), 32'h3C);
        check("wr_dat0", bus.resp.dat, 32'd0);
        check("led_before", led, 32'd0);
        @(negedge clk);
        check("led_after", led, 32'h0000_00A5);
        check("wr_ack_drop", 32'(bus.resp.ack), 32'd0);

        wr(32'hC, 32'h00);
        repeat (2) @(negedge clk);
        badv = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (led !== 32'd0) badv++;
        end
        check("bright0_dark", 32'(badv), 32'd0);
        wr(32'hC, 32'hFF);
        repeat (2) @(negedge clk);
        badv = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (led !== 32'h0000_00A5) badv++;
        end
        check("brightFF_steady", 32'(badv), 32'd0);

        wr(32'h0, 32'hFFFF_FFFF);
        wr(32'hC, 32'h40);
        repeat (2) @(negedge clk);
        cnt = 0;
        badv = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led === 32'hFFFF_FFFF) cnt++;
            else if (led !== 32'd0) badv++;
        end
        check("pwm40_on_count", 32'(cnt), 32'd64);
        check("pwm40_levels", 32'(badv), 32'd0);

        // Blink: led[0] follows the phase, other lit bits stay on.
        wr(32'hC, 32'hFF);
        wr(32'h0, 32'h3);
        wr(32'h4, 32'h1);
        wr(32'h8, 32'h3);
        repeat (2) @(negedge clk);
        badv = 0;
        ntog = 0;
        badint = 0;
        last = -1;
        prev = led[0];
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (led[31:1] !== 31'h1) badv++;
            if (led[0] !== prev) begin
                if (last >= 0 && (i - last) != 4) badint++;
                last = i;
                ntog++;
            end
            prev = led[0];
        end
        check("blink_led1_held", 32'(badv), 32'd0);
        check("blink_interval", 32'(badint), 32'd0);
        check("blink_toggles_ge9", 32'(ntog >= 9), 32'd1);

        // Streaming: write then four reads on consecutive cycles.
        sexp = '{32'd0, 32'h0000_C3C3, 32'h1, 32'h3, 32'hFF};
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h0, 4'hF, 32'h0000_C3C3, 4'd0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("strm%0d_ack", k), 32'(bus.resp.ack), 32'd1);
            check($sformatf("strm%0d_dat", k), bus.resp.dat, sexp[k]);
            check($sformatf("strm%0d_tid", k), 32'(bus.resp.tid), 32'(k));
            if (k < 4) drive(1'b1, 1'b1, 1'b0, 32'(k * 4), 4'h0, 32'd0, 4'd0, 8'(k + 1));
            else       drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 8'd0);
        end
        @(negedge clk);
        check("strm_end_ack", 32'(bus.resp.ack), 32'd0);

        // Selected but no cycle: nothing written, no ack.
        drive(1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 4'd0, 8'd0);
        @(negedge clk);
        check("nocyc_ack", 32'(bus.resp.ack), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 8'd0);
        access(1'b0, 32'h0, 4'h0, 32'd0, 4'd0, 8'd0, a, r);
        check("nocyc_data", r, 32'h0000_C3C3);

        // Reset lands right after an access is accepted.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h0, 4'hF, 32'h0000_FFFF, 4'd1, 8'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstmid_ack", 32'(bus.resp.ack), 32'd0);
        check("rstmid_led", led, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 8'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            access(1'b0, 32'(k * 4), 4'h0, 32'd0, 4'd0, 8'd0, a, r);
            check($sformatf("rst_reg%0d", k), r, vt[k].exp_d);
        end
        check("rst_led_final", led, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
